// File: rtl/mips_wb_arbiter_if.sv
// Writeback arbiter bus: MEM/WB result, long-unit result offer, register-file
// write port, busy mask, stall request and forwarding lookup.
interface mips_wb_arbiter_if;
   logic        pipe_wreg;
   logic [4:0]  pipe_wd;
   logic [31:0] pipe_wdata;
   logic        lu_valid;
   logic [4:0]  lu_wd;
   logic [31:0] lu_wdata;
   logic        lu_ready;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic [31:0] busy_mask;
   logic        stall_req;
   logic [4:0]  fwd_addr;
   logic        fwd_hit;
   logic [31:0] fwd_data;

   modport master (
      output pipe_wreg, pipe_wd, pipe_wdata, lu_valid, lu_wd, lu_wdata, fwd_addr,
      input  lu_ready, we, waddr, wdata, busy_mask, stall_req, fwd_hit, fwd_data
   );

   modport slave (
      input  pipe_wreg, pipe_wd, pipe_wdata, lu_valid, lu_wd, lu_wdata, fwd_addr,
      output lu_ready, we, waddr, wdata, busy_mask, stall_req, fwd_hit, fwd_data
   );
endinterface

// File: rtl/mips_wb_arbiter.sv
// Writeback arbiter: pipe result wins the write port, queued long-unit results
// fill idle slots. Optional FIFO forwarding lookup under `MIPS_WB_FWD_EN.
module mips_wb_arbiter #(
   parameter int DEPTH        = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   mips_wb_arbiter_if.slave  bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   logic [4:0]    wd_mem   [DEPTH];
   logic [31:0]   data_mem [DEPTH];
   logic [PW-1:0] rd_ptr_reg;
   logic [PW-1:0] wr_ptr_reg;
   logic [CW-1:0] count_reg;
   logic [SW-1:0] starve_reg;
   logic          we_reg;
   logic [4:0]    waddr_reg;
   logic [31:0]   wdata_reg;
   logic          stall_reg;

   logic             fifo_full;
   logic             fifo_empty;
   logic             pipe_go;
   logic             push;
   logic             pop;
   logic [DEPTH-1:0] entry_valid;
   logic [31:0]      busy_next;

   assign fifo_full  = (count_reg == CW'(DEPTH));
   assign fifo_empty = (count_reg == '0);
   assign pipe_go    = bus.pipe_wreg && (bus.pipe_wd != 5'd0) && !stall_reg;
   // $0 results are accepted from the unit but never take a slot.
   assign push       = bus.lu_valid && !fifo_full && (bus.lu_wd != 5'd0);
   assign pop        = !pipe_go && !fifo_empty;

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
         logic [PW-1:0] age;
         assign age             = PW'(gi) - rd_ptr_reg;
         assign entry_valid[gi] = ({1'b0, age} < count_reg);
      end
   endgenerate

   always_comb begin
      busy_next = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (entry_valid[i]) begin
            busy_next[wd_mem[i]] = 1'b1;
         end
      end
      busy_next[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (push) begin
         wd_mem[wr_ptr_reg]   <= bus.lu_wd;
         data_mem[wr_ptr_reg] <= bus.lu_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
         starve_reg <= '0;
         we_reg     <= 1'b0;
         waddr_reg  <= 5'd0;
         wdata_reg  <= 32'd0;
         stall_reg  <= 1'b0;
      end else begin
         if (pipe_go) begin
            we_reg    <= 1'b1;
            waddr_reg <= bus.pipe_wd;
            wdata_reg <= bus.pipe_wdata;
         end else if (pop) begin
            we_reg    <= 1'b1;
            waddr_reg <= wd_mem[rd_ptr_reg];
            wdata_reg <= data_mem[rd_ptr_reg];
         end else begin
            we_reg    <= 1'b0;
         end

         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + PW'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PW'(1);
         end
         if (push && !pop) begin
            count_reg <= count_reg + CW'(1);
         end else if (pop && !push) begin
            count_reg <= count_reg - CW'(1);
         end

         // Full FIFO shut out by the pipe: after enough such cycles, freeze it once.
         if (fifo_full && pipe_go) begin
            if (starve_reg == SW'(STARVE_LIMIT - 1)) begin
               starve_reg <= '0;
               stall_reg  <= 1'b1;
            end else begin
               starve_reg <= starve_reg + SW'(1);
               stall_reg  <= 1'b0;
            end
         end else begin
            starve_reg <= '0;
            stall_reg  <= 1'b0;
         end
      end
   end

   assign bus.lu_ready  = !fifo_full;
   assign bus.we        = we_reg;
   assign bus.waddr     = waddr_reg;
   assign bus.wdata     = wdata_reg;
   assign bus.stall_req = stall_reg;
   assign bus.busy_mask = busy_next;

`ifdef MIPS_WB_FWD_EN
   logic          fwd_hit_c;
   logic [31:0]   fwd_data_c;
   logic [PW-1:0] fwd_idx;

   // Walk oldest to youngest so the last match is the youngest.
   always_comb begin
      fwd_hit_c  = 1'b0;
      fwd_data_c = 32'd0;
      fwd_idx    = '0;
      for (int k = 0; k < DEPTH; k++) begin
         fwd_idx = rd_ptr_reg + PW'(k);
         if ((CW'(k) < count_reg) && (bus.fwd_addr != 5'd0) &&
             (wd_mem[fwd_idx] == bus.fwd_addr)) begin
            fwd_hit_c  = 1'b1;
            fwd_data_c = data_mem[fwd_idx];
         end
      end
   end

   assign bus.fwd_hit  = fwd_hit_c;
   assign bus.fwd_data = fwd_data_c;
`else
   logic unused_fwd;
   assign unused_fwd   = ^bus.fwd_addr;
   assign bus.fwd_hit  = 1'b0;
   assign bus.fwd_data = 32'd0;
`endif
endmodule

// File: tb/tb_mips_wb_arbiter.sv
// Writeback arbiter bench: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mips_wb_arbiter;
   localparam int DEPTH = 2;
   localparam int LIMIT = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   mips_wb_arbiter_if bus();

   mips_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic [4:0]  wd;
      logic [31:0] d;
   } ent_t;

   ent_t        q[$];
   logic        m_we;
   logic [4:0]  m_waddr;
   logic [31:0] m_wdata;
   logic        m_stall;
   int          m_starve;
   bit          m_acc;
   int          total = 0;
   int          bad   = 0;
   bit          chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      q.delete();
      m_we = 1'b0; m_waddr = 5'd0; m_wdata = 32'd0;
      m_stall = 1'b0; m_starve = 0; m_acc = 1'b0;
   endtask

   // One clock edge of the arbiter's documented behaviour.
   task automatic model_step();
      int   pre;
      bit   pv;
      ent_t e;
      if (!rst) begin
         model_clear();
         return;
      end
      pre   = q.size();
      pv    = bus.pipe_wreg && (bus.pipe_wd != 0) && !m_stall;
      m_acc = bus.lu_valid && (pre != DEPTH);
      if (pv) begin
         m_we = 1'b1; m_waddr = bus.pipe_wd; m_wdata = bus.pipe_wdata;
      end else if (pre > 0) begin
         e = q.pop_front();
         m_we = 1'b1; m_waddr = e.wd; m_wdata = e.d;
      end else begin
         m_we = 1'b0;
      end
      if (m_acc && bus.lu_wd != 0) q.push_back('{wd: bus.lu_wd, d: bus.lu_wdata});
      if (pre == DEPTH && pv) begin
         m_starve++;
         m_stall = (m_starve == LIMIT);
         if (m_stall) m_starve = 0;
      end else begin
         m_starve = 0;
         m_stall  = 1'b0;
      end
   endtask

   function automatic logic [31:0] exp_busy();
      logic [31:0] m = 32'd0;
      foreach (q[i]) m[q[i].wd] = 1'b1;
      m[0] = 1'b0;
      return m;
   endfunction

   function automatic logic [32:0] exp_fwd(input logic [4:0] a);
      logic [32:0] r = 33'd0;
`ifdef MIPS_WB_FWD_EN
      if (a != 0) foreach (q[i]) if (q[i].wd == a) r = {1'b1, q[i].d};
`else
      r = {28'd0, a} & 33'd0;
`endif
      return r;
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         check("we", bus.we, m_we);
         check("waddr", bus.waddr, m_waddr);
         check("wdata", bus.wdata, m_wdata);
         check("stall_req", bus.stall_req, m_stall);
         check("lu_ready", bus.lu_ready, q.size() != DEPTH);
         check("busy_mask", bus.busy_mask, exp_busy());
         check("fwd", {bus.fwd_hit, bus.fwd_data}, exp_fwd(bus.fwd_addr));
         if (bus.we) $display("write r%0d <= 0x%08h at %0t", bus.waddr, bus.wdata, $time);
      end
   end

   task automatic cyc(input logic pw, input logic [4:0] pd, input logic [31:0] pdat,
                      input logic lv, input logic [4:0] ld, input logic [31:0] ldat,
                      input logic [4:0] fa);
      bus.pipe_wreg = pw; bus.pipe_wd = pd; bus.pipe_wdata = pdat;
      bus.lu_valid  = lv; bus.lu_wd   = ld; bus.lu_wdata   = ldat;
      bus.fwd_addr  = fa;
      @(posedge clk);
      model_step();
      #2;
   endtask

   task automatic idle(input logic [4:0] fa);
      cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, fa);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      logic        pw, lv;
      logic [4:0]  pd, ld, fa;
      logic [31:0] pdat, ldat;
      logic [31:0] bm;

      bus.pipe_wreg = 0; bus.pipe_wd = 0; bus.pipe_wdata = 0;
      bus.lu_valid = 0; bus.lu_wd = 0; bus.lu_wdata = 0; bus.fwd_addr = 0;
      model_clear();
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      chk_en = 1'b1;
      check("rst_we", bus.we, 0);
      check("rst_waddr", bus.waddr, 0);
      check("rst_stall", bus.stall_req, 0);
      check("rst_busy", bus.busy_mask, 0);
      check("rst_ready", bus.lu_ready, 1);
      check("rst_fwd_hit", bus.fwd_hit, 0);

      $display("txn: pipe write r5=0x1234");
      cyc(1, 5, 32'h1234, 0, 0, 0, 0);
      check("t1_we", bus.we, 1);
      check("t1_waddr", bus.waddr, 5);
      check("t1_wdata", bus.wdata, 32'h1234);
      idle(0);
      check("t1_we_off", bus.we, 0);

      $display("txn: long unit r8=0xDEADBEEF");
      cyc(0, 0, 0, 1, 8, 32'hDEADBEEF, 0);
      bm = bus.busy_mask;
      check("t2_busy_set", bm[8], 1);
      check("t2_we_idle", bus.we, 0);
      idle(0);
      bm = bus.busy_mask;
      check("t2_we", bus.we, 1);
      check("t2_waddr", bus.waddr, 8);
      check("t2_wdata", bus.wdata, 32'hDEADBEEF);
      check("t2_busy_clr", bm[8], 0);
      idle(0);

      $display("txn: starvation with full FIFO");
      cyc(1, 1, 32'h11, 1, 9, 32'h900, 0);
      cyc(1, 2, 32'h22, 1, 10, 32'hA00, 0);
      check("t3_ready_full", bus.lu_ready, 0);
      for (int i = 0; i < LIMIT; i++) begin
         check("t3_no_stall", bus.stall_req, 0);
         cyc(1, 5'(3 + i), 32'h33 + i, 0, 0, 0, 0);
      end
      check("t3_stall", bus.stall_req, 1);
      cyc(1, 7, 32'h777, 0, 0, 0, 0);
      check("t3_head_we", bus.we, 1);
      check("t3_head_waddr", bus.waddr, 9);
      check("t3_head_wdata", bus.wdata, 32'h900);
      check("t3_stall_off", bus.stall_req, 0);
      cyc(1, 7, 32'h777, 0, 0, 0, 0);
      check("t3_repeat_waddr", bus.waddr, 7);
      idle(0);
      check("t3_drain_waddr", bus.waddr, 10);
      idle(0);

      $display("txn: writes to r0 from both sources");
      cyc(1, 0, 32'hBAD, 1, 0, 32'hBAD2, 0);
      check("t4_we", bus.we, 0);
      check("t4_busy", bus.busy_mask, 0);
      check("t4_ready", bus.lu_ready, 1);
      idle(0);
      check("t4_no_late_write", bus.we, 0);

      $display("txn: two results to r3");
      cyc(1, 1, 32'h1, 1, 3, 32'hA, 0);
      cyc(1, 2, 32'h2, 1, 3, 32'hB, 3);
      bm = bus.busy_mask;
      check("t5_busy", bm[3], 1);
`ifdef MIPS_WB_FWD_EN
      check("t5_fwd_hit", bus.fwd_hit, 1);
      check("t5_fwd_data", bus.fwd_data, 32'hB);
`else
      check("t5_fwd_hit", bus.fwd_hit, 0);
      check("t5_fwd_data", bus.fwd_data, 0);
`endif
      idle(3);
      bm = bus.busy_mask;
      check("t5_first_wdata", bus.wdata, 32'hA);
      check("t5_busy_hold", bm[3], 1);
      idle(3);
      bm = bus.busy_mask;
      check("t5_second_wdata", bus.wdata, 32'hB);
      check("t5_busy_clr", bm[3], 0);
      check("t5_fwd_miss", bus.fwd_hit, 0);

      $display("txn: reset with two queued results");
      cyc(1, 1, 32'h1, 1, 12, 32'hC1, 0);
      cyc(1, 2, 32'h2, 1, 13, 32'hC2, 0);
      rst = 1'b0;
      model_clear();
      #1;
      check("t6_we", bus.we, 0);
      check("t6_wdata", bus.wdata, 0);
      check("t6_busy", bus.busy_mask, 0);
      check("t6_ready", bus.lu_ready, 1);
      idle(0);
      rst = 1'b1;
      idle(0);
      check("t6_no_stale1", bus.we, 0);
      idle(0);
      check("t6_no_stale2", bus.we, 0);

      $display("txn: randomized traffic");
      lv = 0; ld = 0; ldat = 0; pw = 0; pd = 0; pdat = 0;
      for (int n = 0; n < 3000; n++) begin
         if (!rst) begin
            rst = 1'b1;
         end else if ($urandom_range(0, 399) == 0) begin
            rst = 1'b0;
            model_clear();
            lv = 0;
         end
         if (!m_stall) begin
            pw   = ($urandom_range(0, 9) < 7);
            pd   = 5'($urandom_range(0, 7));
            pdat = $urandom;
         end
         if (!(lv && !m_acc)) begin
            lv   = ($urandom_range(0, 9) < 4);
            ld   = 5'($urandom_range(0, 7));
            ldat = $urandom;
         end
         fa = 5'($urandom_range(0, 7));
         cyc(pw, pd, pdat, lv, ld, ldat, fa);
      end

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mips_wb_arbiter.md
# mips_wb_arbiter

Writeback-stage arbiter that owns the register file's single write port (waddr/wdata/we) and merges two result sources: the in-order MEM/WB pipeline result and out-of-band results from long-latency units (divider, multi-cycle loads). Long-unit results are queued in a small FIFO and written in idle write-port slots. A starvation guard briefly stalls the pipeline so queued results always drain. A per-register busy mask lets decode stall on operands still held in the queue.

## Interface
- DEPTH, 2: long-unit result FIFO entries; power of two, at least 2.
- STARVE_LIMIT, 4: consecutive blocked cycles with a full FIFO before a stall is forced; at least 1.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- pipe_wreg  in  1  MEM/WB result valid.
- pipe_wd  in  5  MEM/WB destination register.
- pipe_wdata  in  32  MEM/WB result data.
- lu_valid  in  1  long-unit result offered.
- lu_wd  in  5  long-unit destination register.
- lu_wdata  in  32  long-unit result data.
- lu_ready  out  1  FIFO can accept; equals (count != DEPTH).
- we  out  1  register file write enable (registered).
- waddr  out  5  register file write address (registered).
- wdata  out  32  register file write data (registered).
- busy_mask  out  32  bit r set while any FIFO entry targets r; bit 0 always 0.
- stall_req  out  1  one-cycle pipeline freeze request (registered).
- fwd_addr  in  5  forwarding lookup address (only with MIPS_WB_FWD_EN).
- fwd_hit  out  1  lookup matched a FIFO entry.
- fwd_data  out  32  data of the youngest matching entry.

## Operation
- Pipe write is valid when pipe_wreg=1, pipe_wd!=0, and stall_req=0.
- Writes to $0 from either source are discarded:
  - pipe: no write is issued;
  - long unit: the result is accepted but not enqueued, so it never occupies the FIFO.
- Write-port priority each cycle:
  1. If the pipe write is valid, it is written.
  2. Otherwise, if the FIFO is non-empty, the head is popped and written.
  3. Otherwise we=0.
- Enqueue occurs when lu_valid=1 and lu_ready=1, at that edge.
  - A newly enqueued entry is not eligible to drain in the same cycle.
  - Enqueue and pop may occur at the same edge; the count is unchanged.
- busy_mask is a function of registered FIFO state only: the OR of one-hot(wd) over valid entries.
  - Duplicate destinations keep the bit set until the last matching entry drains.
- Starvation counter:
  - Increments each cycle in which count==DEPTH and a valid pipe write takes the port.
  - Clears otherwise.
  - On reaching STARVE_LIMIT it clears and stall_req is registered high for exactly one cycle.
- While stall_req=1:
  - pipe inputs are ignored; upstream holds MEM/WB and re-presents the result the following cycle;
  - the FIFO head drains.
- Program-order WAW safety is upstream's duty: decode stalls on busy_mask.

## Timing
- Reset (asynchronous assert, synchronous release): we=0, waddr=0, wdata=0, stall_req=0, busy_mask=0, FIFO empty, lu_ready=1, counter=0, fwd_hit=0, fwd_data=0.
- Reset asserted mid-operation discards all queued results.
- Pipe path latency is 1: inputs in cycle k appear on we/waddr/wdata in cycle k+1.
- Long-unit path latency:
  - With an idle port, a result accepted in cycle k appears as a write in cycle k+2.
  - busy bit r is set in cycle k+1.
  - busy bit r clears in cycle k+2, the same cycle we is high. The register file bypasses same-cycle writes to readers.
- lu_ready depends only on registered count; there is no combinational path from lu_valid.
- Full FIFO: lu_ready=0 and lu_valid is held by the unit. Empty FIFO with no pipe write: we=0.
- Pointers wrap modulo DEPTH.

## Configuration
- MIPS_WB_FWD_EN defined: combinational lookup of fwd_addr against valid FIFO entries.
  - fwd_hit=1 with the youngest matching entry's data.
  - fwd_addr=0 never hits.
- MIPS_WB_FWD_EN undefined:
  - the fwd_addr port remains but is unused;
  - fwd_hit=0 and fwd_data=0 constantly;
  - no comparator logic is built.

## Test plan
- Reset release, then pipe_wreg=1, pipe_wd=5, pipe_wdata=0x1234 for one cycle -> next cycle we=1, waddr=5, wdata=0x1234; then we=0.
- lu_valid with lu_wd=8, lu_wdata=0xDEADBEEF, pipe idle -> busy_mask[8]=1 one cycle later; one cycle after that we=1, waddr=8, busy_mask[8]=0.
- Pipe writes every cycle, two long-unit results queued (DEPTH=2, STARVE_LIMIT=4) -> lu_ready=0; after 4 blocked cycles stall_req=1 for one cycle, during which the head is written and the pipe input is ignored.
- lu_wd=0 or pipe_wd=0 -> no write, busy_mask unchanged, FIFO count unchanged.
- Two entries both to r3 (0xA then 0xB), MIPS_WB_FWD_EN defined, fwd_addr=3 -> fwd_hit=1, fwd_data=0xB; busy_mask[3] stays high until the second write.
- Reset asserted with 2 entries queued -> all outputs zero immediately, lu_ready=1, and no stale writes after release.
